eater_datapath: RTL and testbench
=================================

Name: eater_datapath

Overview:
- SAP-class 8-bit datapath that consumes the 16-bit control word from the microcode sequencer and executes it.
- Contains the shared bus, the PC, MAR, 16x8 RAM, IR, A, B, ALU, flags, output register and halt latch.
- Returns the current opcode (IR[7:4]) to the sequencer, closing the control loop.
- Single clock domain; all state updates on posedge clk.

Parameters:
RAM_DEPTH, 16, number of RAM words; address width is 4 bits and fixed.
DATA_W, 8, bus and register width; only 8 is supported.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
ctrl_data  input  16  control word: bit15 reserved (ignored), 14 HLT, 13 MI, 12 RI, 11 RO, 10 IO, 9 II, 8 AI, 7 AO, 6 EO, 5 SU, 4 BI, 3 OI, 2 CE, 1 CO, 0 J
instruction  output  4  IR[7:4], opcode to the sequencer
prog_we  input  1  program-load RAM write enable
prog_addr  input  4  program-load address
prog_data  input  8  program-load data
out_value  output  8  output register
out_valid  output  1  one-cycle pulse after an OI load
carry_flag  output  1  ALU carry from the last EO cycle
zero_flag  output  1  ALU zero from the last EO cycle
halted  output  1  sticky halt indicator
bus_err  output  1  sticky: more than one bus driver asserted
pc_value  output  4  program counter (debug)

Behaviour:
- Reset (async, rst=1): PC, MAR, IR, A, B, out_value, out_valid, carry_flag, zero_flag, halted and bus_err all go to 0. RAM contents are not reset.
- ctrl_data is registered by the sequencer. The word present during a cycle is sampled and executed at the next posedge. All loads use pre-edge register values.
- Bus (combinational):
  - Driver priority is RO > IO > AO > EO > CO.
  - RO drives RAM[MAR]. IO drives {4'b0, IR[3:0]}. AO drives A. EO drives the ALU result. CO drives {4'b0, PC}.
  - With no driver asserted, bus = 0.
  - Two or more drivers asserted sets bus_err at that edge. bus_err stays set until reset; the bus still takes the priority winner.
- ALU:
  - SU=0: sum = A + B. SU=1: sum = A + ~B + 1.
  - Result is 8-bit, wrap-around; carry is bit 8 of the 9-bit sum (SU=1, A>=B gives carry=1).
  - The ALU output is always computed. Flags update only at edges where EO=1: carry_flag <= carry, zero_flag <= (sum == 0).
- Loads at the edge:
  - MI: MAR <= bus[3:0].
  - RI: RAM[MAR] <= bus.
  - II: IR <= bus.
  - AI: A <= bus.
  - BI: B <= bus.
  - OI: out_value <= bus, out_valid <= 1. out_valid is 0 at every other edge.
- PC:
  - J: PC <= bus[3:0]; J overrides CE when both are set.
  - CE only: PC <= PC+1 mod 16 (15 wraps to 0).
- Program load: prog_we=1 writes RAM[prog_addr] <= prog_data. This is accepted in any state, including halted. If RI is also active in the same edge, prog_we wins and the RI write is dropped.
- Halt:
  - HLT=1 sets halted at the edge. The other bits of that same word still execute.
  - While halted=1, all ctrl_data bits are ignored: no register, flag, RAM (except prog_we) or PC updates, and out_valid stays 0.
  - Only reset clears halted.
  - Reset asserted mid-instruction clears state immediately; the first edge after deassertion executes whatever ctrl_data is present.
- instruction = IR[7:4], combinational from IR; 0 after reset.

Test Plan:
1. Reset check: assert rst with random state, then sample asynchronously before the next clk -> all outputs 0; RAM[3]=0x5A preloaded via prog_we is still 0x5A.
2. Fetch:
   - Preload RAM[0]=0x1E.
   - Apply CO|MI, then RO|II|CE -> IR=0x1E, instruction=1, pc_value=1, bus_err=0.
3. LDA 14:
   - Preload RAM[14]=0x1C, IR=0x1E.
   - Apply IO|MI, then RO|AI -> A=0x1C.
4. ALU:
   - Add: A=0xF0, B=0x20, EO|AI -> A=0x10, carry_flag=1, zero_flag=0.
   - Subtract: A=0x05, B=0x05, EO|SU|AI -> A=0x00, carry_flag=1, zero_flag=1.
   - Underflow: A=0x03, B=0x05, SU -> result 0xFE, carry_flag=0.
5. Jump, wrap and conflict:
   - IR=0x47, PC=2, IO|J|CE -> PC=7.
   - PC=15, CE -> PC=0.
   - AO|CO together -> bus equals A, bus_err=1 and stays 1 until rst.
6. OUT and halt:
   - A=0x2A, AO|OI -> out_value=0x2A, out_valid high for exactly one cycle.
   - Then HLT, then CE|AI -> halted=1, PC and A unchanged.
   - prog_we still writes RAM.
   - rst pulse -> halted=0.

Source files
------------

// File: rtl/eater_datapath.sv
// eater_datapath: SAP-class 8-bit datapath. Executes the 16-bit control word
// from the microcode sequencer and returns the current opcode (IR[7:4]).
module eater_datapath #(
    parameter int RAM_DEPTH = 16,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ctrl_data,
    output logic [3:0]        instruction,
    input  logic              prog_we,
    input  logic [3:0]        prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_value,
    output logic              out_valid,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              halted,
    output logic              bus_err,
    output logic [3:0]        pc_value
);

    // Control word bit positions (bit 15 is reserved and ignored)
    localparam int B_HLT = 14;
    localparam int B_MI  = 13;
    localparam int B_RI  = 12;
    localparam int B_RO  = 11;
    localparam int B_IO  = 10;
    localparam int B_II  = 9;
    localparam int B_AI  = 8;
    localparam int B_AO  = 7;
    localparam int B_EO  = 6;
    localparam int B_SU  = 5;
    localparam int B_BI  = 4;
    localparam int B_OI  = 3;
    localparam int B_CE  = 2;
    localparam int B_CO  = 1;
    localparam int B_J   = 0;

    logic [3:0]        r_pc;
    logic [3:0]        r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;
    logic              r_carry;
    logic              r_zero;
    logic              r_halted;
    logic              r_bus_err;
    logic [DATA_W-1:0] r_ram [0:RAM_DEPTH-1];

    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_ram_rd;
    logic [DATA_W-1:0] w_b_op;
    logic [DATA_W:0]   w_sum;
    logic [2:0]        w_drv_cnt;
    logic              w_multi;
    logic              w_exec;

    assign w_exec   = ~r_halted;
    assign w_ram_rd = r_ram[r_mar];

    // Bus driver count, used to flag contention
    always_comb begin
        w_drv_cnt = {2'b00, ctrl_data[B_RO]} + {2'b00, ctrl_data[B_IO]}
                  + {2'b00, ctrl_data[B_AO]} + {2'b00, ctrl_data[B_EO]}
                  + {2'b00, ctrl_data[B_CO]};
        w_multi   = (w_drv_cnt > 3'd1);
    end

    // ALU: add, or subtract via two's complement of B; always computed
    always_comb begin
        if (ctrl_data[B_SU]) begin
            w_b_op = ~r_b;
        end else begin
            w_b_op = r_b;
        end
        w_sum = {1'b0, r_a} + {1'b0, w_b_op} + {8'h00, ctrl_data[B_SU]};
    end

    // Shared bus: priority mux RO > IO > AO > EO > CO, zero when undriven
    always_comb begin
        w_bus = 8'h00;
        if (ctrl_data[B_RO]) begin
            w_bus = w_ram_rd;
        end else if (ctrl_data[B_IO]) begin
            w_bus = {4'h0, r_ir[3:0]};
        end else if (ctrl_data[B_AO]) begin
            w_bus = r_a;
        end else if (ctrl_data[B_EO]) begin
            w_bus = w_sum[7:0];
        end else if (ctrl_data[B_CO]) begin
            w_bus = {4'h0, r_pc};
        end else begin
            w_bus = 8'h00;
        end
    end

    // Register loads, flags, PC and halt latch; frozen while halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= 4'h0;
            r_mar       <= 4'h0;
            r_ir        <= 8'h00;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_out       <= 8'h00;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_halted    <= 1'b0;
            r_bus_err   <= 1'b0;
        end else if (w_exec) begin
            if (ctrl_data[B_MI]) r_mar <= w_bus[3:0];
            if (ctrl_data[B_II]) r_ir  <= w_bus;
            if (ctrl_data[B_AI]) r_a   <= w_bus;
            if (ctrl_data[B_BI]) r_b   <= w_bus;
            if (ctrl_data[B_OI]) r_out <= w_bus;
            r_out_valid <= ctrl_data[B_OI];
            if (ctrl_data[B_EO]) begin
                r_carry <= w_sum[8];
                r_zero  <= (w_sum[7:0] == 8'h00);
            end
            if (ctrl_data[B_J]) begin
                r_pc <= w_bus[3:0];
            end else if (ctrl_data[B_CE]) begin
                r_pc <= r_pc + 4'd1;
            end
            if (ctrl_data[B_HLT]) r_halted  <= 1'b1;
            if (w_multi)          r_bus_err <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // Program RAM: loader port has priority over the RI bus write
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_ram[prog_addr] <= prog_data;
        end else if (w_exec && ctrl_data[B_RI]) begin
            r_ram[r_mar] <= w_bus;
        end
    end

    assign instruction = r_ir[7:4];
    assign out_value   = r_out;
    assign out_valid   = r_out_valid;
    assign carry_flag  = r_carry;
    assign zero_flag   = r_zero;
    assign halted      = r_halted;
    assign bus_err     = r_bus_err;
    assign pc_value    = r_pc;

endmodule

// File: tb/tb_eater_datapath.sv
// Testbench for eater_datapath: directed and random control words checked
// against a behavioural model through an expected-output scoreboard.
module tb_eater_datapath;

    localparam logic [15:0] HLT = 16'h4000, MI = 16'h2000, RI = 16'h1000,
                            RO  = 16'h0800, IO = 16'h0400, II = 16'h0200,
                            AI  = 16'h0100, AO = 16'h0080, EO = 16'h0040,
                            SU  = 16'h0020, BI = 16'h0010, OI = 16'h0008,
                            CE  = 16'h0004, CO = 16'h0002, J  = 16'h0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ctrl_data = 16'h0000;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'h0;
    logic [7:0]  prog_data = 8'h00;
    logic [3:0]  instruction, pc_value;
    logic [7:0]  out_value;
    logic        out_valid, carry_flag, zero_flag, halted, bus_err;

    eater_datapath dut (
        .clk(clk), .rst(rst), .ctrl_data(ctrl_data), .instruction(instruction),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .out_value(out_value), .out_valid(out_valid), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .halted(halted), .bus_err(bus_err),
        .pc_value(pc_value)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int pc; int ins; int outv; int ov; int c; int z; int h; int e;
    } exp_t;
    exp_t sb[$];

    // Behavioural model state (plain integers)
    int m_pc, m_mar, m_ir, m_a, m_b, m_out, m_ov, m_c, m_z, m_h, m_err;
    int m_ram[16];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
        m_ov = 0; m_c = 0; m_z = 0; m_h = 0; m_err = 0;
    endtask

    // One clock edge of architectural behaviour
    task automatic model_step(input logic [15:0] cw, input logic pwe,
                              input int pa, input int pd);
        int sum, res, bus, n;
        sum = cw[5] ? (m_a + 256 - m_b) : (m_a + m_b);
        res = sum % 256;
        n = 0; bus = 0;
        // lowest priority first so the highest-priority driver is assigned last
        if (cw[1])  begin n++; bus = m_pc; end
        if (cw[6])  begin n++; bus = res; end
        if (cw[7])  begin n++; bus = m_a; end
        if (cw[10]) begin n++; bus = m_ir % 16; end
        if (cw[11]) begin n++; bus = m_ram[m_mar]; end
        if (m_h == 0) begin
            if (cw[12] && !pwe) m_ram[m_mar] = bus;
            if (cw[0])      m_pc = bus % 16;
            else if (cw[2]) m_pc = (m_pc + 1) % 16;
            if (cw[13]) m_mar = bus % 16;
            if (cw[9])  m_ir = bus;
            if (cw[8])  m_a = bus;
            if (cw[4])  m_b = bus;
            if (cw[3])  m_out = bus;
            m_ov = cw[3];
            if (cw[6]) begin m_c = (sum >= 256); m_z = (res == 0); end
            if (cw[14]) m_h = 1;
            if (n > 1)  m_err = 1;
        end else begin
            m_ov = 0;
        end
        if (pwe) m_ram[pa] = pd;
    endtask

    // Drive one control word for one edge and queue the expected outputs
    task automatic cyc(input logic [15:0] cw, input logic pwe = 1'b0,
                       input logic [3:0] pa = 4'h0, input logic [7:0] pd = 8'h00);
        exp_t e;
        @(negedge clk);
        ctrl_data = cw; prog_we = pwe; prog_addr = pa; prog_data = pd;
        model_step(cw, pwe, int'(pa), int'(pd));
        e.pc = m_pc; e.ins = m_ir / 16; e.outv = m_out; e.ov = m_ov;
        e.c = m_c; e.z = m_z; e.h = m_h; e.e = m_err;
        sb.push_back(e);
    endtask

    // Monitor: compare every post-edge output set with the queued expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_value",    int'(pc_value),    e.pc);
            chk("instruction", int'(instruction), e.ins);
            chk("out_value",   int'(out_value),   e.outv);
            chk("out_valid",   int'(out_valid),   e.ov);
            chk("carry_flag",  int'(carry_flag),  e.c);
            chk("zero_flag",   int'(zero_flag),   e.z);
            chk("halted",      int'(halted),      e.h);
            chk("bus_err",     int'(bus_err),     e.e);
        end
    end

    // Mid-cycle asynchronous reset with immediate output check
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_pc",    int'(pc_value),    0);
        chk("rst_ins",   int'(instruction), 0);
        chk("rst_out",   int'(out_value),   0);
        chk("rst_ov",    int'(out_valid),   0);
        chk("rst_c",     int'(carry_flag),  0);
        chk("rst_z",     int'(zero_flag),   0);
        chk("rst_h",     int'(halted),      0);
        chk("rst_err",   int'(bus_err),     0);
        model_reset();
        ctrl_data = 16'h0000; prog_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic load_a(input logic [7:0] v);
        cyc(16'h0000, 1'b1, 4'(m_mar), v);
        cyc(RO | AI);
    endtask

    task automatic load_b(input logic [7:0] v);
        cyc(16'h0000, 1'b1, 4'(m_mar), v);
        cyc(RO | BI);
    endtask

    initial begin
        logic [15:0] rcw;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset with random state; RAM survives
        cyc(16'h0000, 1'b1, 4'd3, 8'h5A);
        for (int i = 0; i < 30; i++) begin
            rcw = 16'($urandom) & ~(HLT | RI);
            cyc(rcw);
        end
        do_reset();
        cyc(16'h0000, 1'b1, 4'd0, 8'h03);
        cyc(RO | MI);
        cyc(RO | AI);
        cyc(AO | OI);
        settle();
        chk("ram3_kept", int'(out_value), 8'h5A);
        do_reset();

        // Fetch
        cyc(16'h0000, 1'b1, 4'd0, 8'h1E);
        cyc(CO | MI);
        cyc(RO | II | CE);
        settle();
        chk("fetch_ins", int'(instruction), 1);
        chk("fetch_pc",  int'(pc_value),    1);
        chk("fetch_err", int'(bus_err),     0);

        // LDA 14
        cyc(16'h0000, 1'b1, 4'd14, 8'h1C);
        cyc(IO | MI);
        cyc(RO | AI);
        cyc(AO | OI);
        settle();
        chk("lda_a", int'(out_value), 8'h1C);

        // ALU add with carry
        load_a(8'hF0); load_b(8'h20);
        cyc(EO | AI);
        cyc(AO | OI);
        settle();
        chk("add_res", int'(out_value), 8'h10);
        chk("add_c",   int'(carry_flag), 1);
        chk("add_z",   int'(zero_flag),  0);
        // Subtract to zero
        load_a(8'h05); load_b(8'h05);
        cyc(EO | SU | AI);
        settle();
        chk("sub_c", int'(carry_flag), 1);
        chk("sub_z", int'(zero_flag),  1);
        // Underflow
        load_a(8'h03); load_b(8'h05);
        cyc(EO | SU | OI);
        settle();
        chk("uf_res", int'(out_value),  8'hFE);
        chk("uf_c",   int'(carry_flag), 0);

        // Jump overrides CE
        cyc(16'h0000, 1'b1, 4'(m_mar), 8'h02);
        cyc(RO | J);
        cyc(16'h0000, 1'b1, 4'(m_mar), 8'h47);
        cyc(RO | II);
        cyc(IO | J | CE);
        settle();
        chk("jmp_pc", int'(pc_value), 7);
        // PC wrap
        cyc(16'h0000, 1'b1, 4'(m_mar), 8'h0F);
        cyc(RO | J);
        cyc(CE);
        settle();
        chk("wrap_pc", int'(pc_value), 0);

        // Random control words against the model
        for (int i = 0; i < 400; i++) begin
            rcw = 16'($urandom) & ~HLT;
            if ($urandom_range(0, 3) == 0)
                cyc(rcw, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
            else
                cyc(rcw);
        end
        do_reset();

        // Bus conflict: priority winner still drives, error is sticky
        load_a(8'h33);
        cyc(AO | CO | OI);
        settle();
        chk("conf_bus", int'(out_value), 8'h33);
        chk("conf_err", int'(bus_err),   1);
        cyc(CE); cyc(16'h0000);
        settle();
        chk("conf_sticky", int'(bus_err), 1);

        // OUT pulse
        load_a(8'h2A);
        cyc(AO | OI);
        settle();
        chk("out_val",   int'(out_value), 8'h2A);
        chk("out_pulse", int'(out_valid), 1);
        cyc(16'h0000);
        settle();
        chk("out_drop", int'(out_valid), 0);

        // Halt freezes execution; program load still works
        cyc(HLT);
        cyc(CE | AI);
        cyc(AO | OI | CE);
        cyc(16'h0000, 1'b1, 4'd5, 8'h77);
        settle();
        chk("halt_h",  int'(halted),    1);
        chk("halt_ov", int'(out_valid), 0);
        do_reset();
        cyc(16'h0000, 1'b1, 4'd0, 8'h05);
        cyc(RO | MI);
        cyc(RO | OI);
        settle();
        chk("halt_prog", int'(out_value), 8'h77);
        chk("unhalt",    int'(halted),    0);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
